// File: rtl/rtc_timer.sv
// Real-time clock timer: mck divider -> tick -> second -> minute chain with
// sticky status, maskable interrupt, minute alarm and a byte-wide register port.
module rtc_timer #(
    parameter int unsigned TICK_DIV = 49152,
    parameter int unsigned TPS      = 200,
    parameter int unsigned MIN_W    = 21
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       restim,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [3:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       int_n,
    output logic       t_1s,
    output logic       t_5ms
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned T0_W  = (TPS > 1) ? $clog2(TPS) : 1;
    localparam int unsigned T1_W  = 6;
    localparam int unsigned EXT_W = 24;

    logic [DIV_W-1:0] div_q;
    logic [T0_W-1:0]  tim0_q;
    logic [T1_W-1:0]  tim1_q;
    logic [MIN_W-1:0] min_q;
    logic [T1_W-1:0]  tim1_sh_q;
    logic [MIN_W-1:0] min_sh_q;
    logic [3:0]       tsta_q;
    logic [3:0]       tmk_q;
    logic [MIN_W-1:0] alm_q;

    logic             tick_ev;
    logic             sec_ev;
    logic             min_ev;
    logic             alm_ev;
    logic [MIN_W-1:0] min_inc;
    logic [3:0]       tsta_set;
    logic [3:0]       tsta_ack;
    logic [EXT_W-1:0] alm_ext;
    logic [EXT_W-1:0] alm_nxt;
    logic [EXT_W-1:0] min_sh_ext;
    logic [7:0]       rd_mux;
    logic [T0_W:0]    tim0_x;

    // Event chain; restim suppresses every event at its source
    assign tick_ev = !restim && (div_q == DIV_W'(TICK_DIV - 1));
    assign sec_ev  = tick_ev && (tim0_q == T0_W'(TPS - 1));
    assign min_ev  = sec_ev && (tim1_q == T1_W'(59));
    assign min_inc = min_q + MIN_W'(1);
    assign alm_ev  = min_ev && (min_inc == alm_q);

    assign tim0_x = {1'b0, tim0_q};
    assign t_1s   = tim0_q[T0_W-1];
    assign t_5ms  = tim0_x[1];

    // Register-port decode: status set/ack, alarm byte merge, read mux
    always_comb begin
        tsta_set   = {alm_ev, min_ev, sec_ev, tick_ev};
        tsta_ack   = 4'h0;
        alm_ext    = EXT_W'(alm_q);
        alm_nxt    = alm_ext;
        min_sh_ext = EXT_W'(min_sh_q);
        rd_mux     = 8'h00;

        if (io_wr && (io_addr == 4'd6)) begin
            tsta_ack = io_wdata[3:0];
        end

        if (io_wr) begin
            case (io_addr)
                4'd7:    alm_nxt[7:0]   = io_wdata;
                4'd8:    alm_nxt[15:8]  = io_wdata;
                4'd9:    alm_nxt[23:16] = io_wdata;
                default: alm_nxt        = alm_ext;
            endcase
        end

        case (io_addr)
            4'd0:    rd_mux = 8'(tim0_q);
            4'd1:    rd_mux = 8'(tim1_sh_q);
            4'd2:    rd_mux = min_sh_ext[7:0];
            4'd3:    rd_mux = min_sh_ext[15:8];
            4'd4:    rd_mux = min_sh_ext[23:16];
            4'd5:    rd_mux = {4'h0, tsta_q};
            4'd7:    rd_mux = alm_ext[7:0];
            4'd8:    rd_mux = alm_ext[15:8];
            4'd9:    rd_mux = alm_ext[23:16];
            default: rd_mux = 8'h00;
        endcase
    end

    // Divider and time counters
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            div_q  <= '0;
            tim0_q <= '0;
            tim1_q <= '0;
            min_q  <= '0;
        end else if (restim) begin
            div_q  <= '0;
            tim0_q <= '0;
            tim1_q <= '0;
            min_q  <= '0;
        end else begin
            div_q <= tick_ev ? '0 : div_q + DIV_W'(1);
            if (tick_ev) begin
                tim0_q <= sec_ev ? '0 : tim0_q + T0_W'(1);
            end
            if (sec_ev) begin
                tim1_q <= min_ev ? '0 : tim1_q + T1_W'(1);
            end
            if (min_ev) begin
                min_q <= min_inc;
            end
        end
    end

    // Shadow of TIM1/MIN, captured by a TIM0 read so multi-byte reads are coherent
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            tim1_sh_q <= '0;
            min_sh_q  <= '0;
        end else if (restim) begin
            tim1_sh_q <= '0;
            min_sh_q  <= '0;
        end else if (io_rd && (io_addr == 4'd0)) begin
            tim1_sh_q <= tim1_q;
            min_sh_q  <= min_q;
        end
    end

    // Status, mask, alarm, read data and interrupt registers
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            tsta_q   <= 4'h0;
            tmk_q    <= 4'h0;
            alm_q    <= '0;
            io_rdata <= 8'h00;
            int_n    <= 1'b1;
        end else begin
            tsta_q <= (tsta_q & ~tsta_ack) | tsta_set;
            alm_q  <= MIN_W'(alm_nxt);
            int_n  <= ~|(tsta_q & tmk_q);
            if (io_wr && (io_addr == 4'd5)) begin
                tmk_q <= io_wdata[3:0];
            end
            if (io_rd) begin
                io_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timer.sv
// Self-checking bench for rtc_timer (TICK_DIV=4, TPS=4, MIN_W=17); read data
// is checked through a scoreboard queue filled when each read is issued.
module tb_rtc_timer;

    logic       mck = 1'b0;
    logic       rin_n = 1'b0;
    logic       restim = 1'b0;
    logic       io_rd = 1'b0;
    logic       io_wr = 1'b0;
    logic [3:0] io_addr = 4'h0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;
    logic       int_n;
    logic       t_1s;
    logic       t_5ms;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    string      tag_q[$];
    logic [7:0] exp_q[$];
    string      mon_tag;
    logic [7:0] mon_exp;

    rtc_timer #(.TICK_DIV(4), .TPS(4), .MIN_W(17)) dut (
        .mck      (mck),
        .rin_n    (rin_n),
        .restim   (restim),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .int_n    (int_n),
        .t_1s     (t_1s),
        .t_5ms    (t_5ms)
    );

    always #5 mck = ~mck;

    // Reference time base: mck edges since last reset/restim
    always @(posedge mck or negedge rin_n) begin
        if (!rin_n)      cyc <= 0;
        else if (restim) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    function automatic int exp_tim0(input int c); return (c / 4) % 4;   endfunction
    function automatic int exp_tim1(input int c); return (c / 16) % 60; endfunction
    function automatic int exp_min(input int c);  return c / 960;       endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read scoreboard: compare io_rdata one cycle after each read strobe
    always @(posedge mck) begin
        if (rin_n && io_rd) begin
            #1;
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check(mon_tag, io_rdata, mon_exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge mck);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string tag);
        io_rd = 1'b1;
        io_addr = a;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge mck);
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        io_wr = 1'b1;
        io_addr = a;
        io_wdata = d;
        @(negedge mck);
        io_wr = 1'b0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] e, input string tag);
        io_rd = 1'b1;
        io_wr = 1'b1;
        io_addr = a;
        io_wdata = d;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge mck);
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic wait_cyc(input int target, input string tag);
        int n = 0;
        while (cyc != target && n < 3000) begin
            @(negedge mck);
            n++;
        end
        if (cyc != target) check(tag, cyc, target);
    endtask

    task automatic wait_mod(input int m, input int r, input string tag);
        int n = 0;
        while ((cyc % m) != r && n < 16) begin
            @(negedge mck);
            n++;
        end
        if ((cyc % m) != r) check(tag, cyc % m, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Held in reset
        step(3);
        check("rst_rdata", io_rdata, 8'h00);
        check("rst_int_n", int_n, 1'b1);
        check("rst_t_1s", t_1s, 1'b0);
        check("rst_t_5ms", t_5ms, 1'b0);
        rin_n = 1'b1;

        // Four ticks: TIM0 back to 0, tick+second status, no interrupt
        wait_cyc(16, "wait_16");
        check("int_n_tmk0", int_n, 1'b1);
        rd(4'd0, 8'h00, "tim0_after_4_ticks");
        rd(4'd5, 8'h03, "tsta_tick_sec");

        // Mask tick: int_n falls two cycles after the write
        wr(4'd5, 8'h01);
        check("int_n_mask_1cyc", int_n, 1'b1);
        step(1);
        check("int_n_mask_2cyc", int_n, 1'b0);

        // Ack coinciding with a tick: set wins
        wait_mod(4, 3, "wait_tick_slot");
        wr(4'd6, 8'h01);
        rd(4'd5, 8'h03, "tsta_set_wins");
        check("int_n_set_wins", int_n, 1'b0);

        // Ack away from a tick clears, interrupt released
        wait_mod(4, 0, "wait_quiet_slot");
        wr(4'd6, 8'h03);
        rd(4'd5, 8'h00, "tsta_acked");
        check("int_n_acked", int_n, 1'b1);
        wr(4'd5, 8'h00);

        // One minute: shadowed TIM1/MIN read
        wait_cyc(960, "wait_min1");
        rd(4'd0, 8'h00, "min1_tim0");
        rd(4'd1, 8'h00, "min1_tim1");
        wait_cyc(1925, "wait_min2");
        check("t_5ms", t_5ms, (exp_tim0(cyc) >> 1) & 1);
        check("t_1s", t_1s, (exp_tim0(cyc) >> 1) & 1);
        rd(4'd2, 8'h01, "shadow_min_held");
        rd(4'd3, 8'h00, "shadow_min_b1");
        rd(4'd4, 8'h00, "shadow_min_b2");
        s = cyc;
        rd(4'd0, 8'(exp_tim0(s)), "tim0_live");
        rd(4'd2, 8'(exp_min(s)), "shadow_min_new");
        rd(4'd1, 8'(exp_tim1(s)), "shadow_tim1_new");

        // Alarm setup, then restim over a tick slot
        wr(4'd7, 8'h02);
        wr(4'd8, 8'h00);
        wr(4'd9, 8'h00);
        wr(4'd5, 8'h08);
        s = cyc;
        rd(4'd0, 8'(exp_tim0(s)), "tim0_pre_restim");
        wait_mod(4, 0, "wait_pre_ack");
        wr(4'd6, 8'h01);
        wait_mod(4, 3, "wait_restim_slot");
        restim = 1'b1;
        step(3);
        restim = 1'b0;
        rd(4'd2, 8'h00, "shadow_cleared");
        rd(4'd5, 8'h06, "tsta_kept_restim");
        rd(4'd7, 8'h02, "alm0_kept");
        rd(4'd8, 8'h00, "alm1_kept");
        rd(4'd9, 8'h00, "alm2_kept");
        wr(4'd6, 8'h0F);
        s = cyc;
        rd(4'd0, 8'(exp_tim0(s)), "tim0_after_restim");
        rd(4'd1, 8'h00, "tim1_after_restim");
        rd(4'd4, 8'h00, "min_b2_after_restim");
        check("int_n_pre_alarm", int_n, 1'b1);

        // Alarm on second minute event only
        wait_cyc(962, "wait_alm_min1");
        check("int_n_no_alarm_min1", int_n, 1'b1);
        wait_cyc(1920, "wait_alm_min2");
        check("int_n_alarm_edge", int_n, 1'b1);
        step(1);
        check("int_n_alarm", int_n, 1'b0);
        wr(4'd6, 8'h08);
        check("int_n_ack_pending", int_n, 1'b0);
        step(1);
        check("int_n_alarm_acked", int_n, 1'b1);

        // Simultaneous read/write, truncated alarm bits, unmapped index
        rdwr(4'd7, 8'h55, 8'h02, "rdwr_old_value");
        rd(4'd7, 8'h55, "alm0_written");
        wr(4'd9, 8'hFF);
        rd(4'd9, 8'h01, "alm2_truncated");
        wr(4'd10, 8'hAA);
        rd(4'd10, 8'h00, "unmapped_10");
        rd(4'd15, 8'h00, "unmapped_15");

        // Asynchronous reset mid-cycle
        wr(4'd5, 8'h01);
        step(2);
        check("int_n_pre_reset", int_n, 1'b0);
        rd(4'd7, 8'h55, "alm0_pre_reset");
        @(posedge mck);
        #2;
        rin_n = 1'b0;
        #1;
        check("async_rdata", io_rdata, 8'h00);
        check("async_int_n", int_n, 1'b1);
        check("async_t_1s", t_1s, 1'b0);
        check("async_t_5ms", t_5ms, 1'b0);
        step(2);
        rin_n = 1'b1;
        rd(4'd5, 8'h00, "tsta_after_reset");
        rd(4'd7, 8'h00, "alm_after_reset");
        rd(4'd0, 8'h00, "tim0_after_reset");
        step(3);
        check("int_n_after_reset", int_n, 1'b1);

        step(2);
        if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
